// File: rtl/mul_div_unit_pkg.sv
// mduPkg: shared opcode/state types and iteration count for the iterative multiply/divide unit
package mduPkg;
  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} mdu_op;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state;
  localparam int ITER = 32;
  function automatic logic is_rem(mdu_op op);
    return op[2] & op[1];
  endfunction
endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response handshake between the core (master) and the unit (slave)
interface mul_div_unit_if;
  import mduPkg::*;
  logic req_valid;
  logic req_ready;
  mdu_op req_op;
  logic [31:0] req_in1;
  logic [31:0] req_in2;
  logic rsp_valid;
  logic rsp_ready;
  logic [31:0] rsp_out;
  logic flush;
  modport master (
    output req_valid, req_op, req_in1, req_in2, rsp_ready, flush,
    input  req_ready, rsp_valid, rsp_out
  );
  modport slave (
    input  req_valid, req_op, req_in1, req_in2, rsp_ready, flush,
    output req_ready, rsp_valid, rsp_out
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: operand magnitudes plus result sign for an op, and the final two's-complement correction
module mdu_sign_fix
  import mduPkg::*;
(
  input  mdu_op       op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] mag1,
  output logic [31:0] mag2,
  output logic        neg,
  input  logic [63:0] raw,
  input  logic        raw_neg,
  output logic [63:0] fixed
);
  logic s1, s2;
  assign s1 = in1[31] && (op inside {MUL, MULH, MULHSU, DIV, REM});
  assign s2 = in2[31] && (op inside {MUL, MULH, DIV, REM});
  assign mag1 = s1 ? -in1 : in1;
  assign mag2 = s2 ? -in2 : in2;
  // remainder takes the dividend's sign; everything else the XOR of both
  assign neg = op == REM ? s1 : s1 ^ s2;
  assign fixed = raw_neg ? -raw : raw;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: 32-iteration shift-add multiplier / restoring divider with valid-ready handshake
module mul_div_unit
  import mduPkg::*;
(
  input logic clk,
  input logic rst,
  mul_div_unit_if.slave bus
);
  mdu_state state, state_n;
  mdu_op op_q;
  logic [31:0] dvs, res, res_n, mag1, mag2, special_res;
  logic [63:0] p, p_n, mul_n, div_n, fix_raw, fixed;
  logic [32:0] sum;
  logic [33:0] trial;
  logic [5:0] cnt;
  logic neg, neg_q, accept, div0, ovf, last;
  mdu_sign_fix u_sign_fix (
    .op(bus.req_op), .in1(bus.req_in1), .in2(bus.req_in2),
    .mag1, .mag2, .neg, .raw(fix_raw), .raw_neg(neg_q), .fixed
  );
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == DONE;
  assign bus.rsp_out = res;
  assign accept = bus.req_valid && state == IDLE && !bus.flush;
  assign div0 = bus.req_op[2] && bus.req_in2 == '0;
  assign ovf = (bus.req_op == DIV || bus.req_op == REM) && bus.req_in1 == 32'h8000_0000 && bus.req_in2 == '1;
  assign special_res = div0 ? (is_rem(bus.req_op) ? bus.req_in1 : '1) : (is_rem(bus.req_op) ? '0 : 32'h8000_0000);
  // p holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign sum = {1'b0, p[63:32]} + (p[0] ? {1'b0, dvs} : 33'd0);
  assign mul_n = {sum, p[31:1]};
  assign trial = {1'b0, p[63:31]} - {2'b0, dvs};
  assign div_n = trial[33] ? {p[62:0], 1'b0} : {trial[31:0], p[30:0], 1'b1};
  assign p_n = op_q[2] ? div_n : mul_n;
  assign fix_raw = !op_q[2] ? p_n : {32'd0, is_rem(op_q) ? p_n[63:32] : p_n[31:0]};
  assign res_n = (op_q == MUL || op_q[2]) ? fixed[31:0] : fixed[63:32];
  assign last = cnt == 6'(ITER - 1);
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? (div0 || ovf ? DONE : CALC) : IDLE)
            : state == CALC ? (bus.flush ? IDLE : last ? DONE : CALC)
            : (bus.flush || bus.rsp_ready) ? IDLE : DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q <= MUL;
      dvs <= '0;
      p <= '0;
      neg_q <= 1'b0;
      cnt <= '0;
      res <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q <= bus.req_op;
        dvs <= mag2;
        p <= {32'd0, mag1};
        neg_q <= neg;
        cnt <= '0;
        if (div0 || ovf) res <= special_res;
      end else if (state == CALC && !bus.flush) begin
        p <= p_n;
        cnt <= cnt + 1'b1;
        if (last) res <= res_n;
      end
    end
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port req_valid, input, 1 bit: the core presents an operation.
REQ-004 SHALL have port req_ready, output, 1 bit: the unit accepts an operation this cycle.
REQ-005 SHALL have port req_op, input, mdu_op (3 bits): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-006 SHALL have ports req_in1 and req_in2, inputs, 32 bits each: rs1 and rs2 operands.
REQ-007 SHALL have port rsp_valid, output, 1 bit: the result is available.
REQ-008 SHALL have port rsp_ready, input, 1 bit: the core takes the result.
REQ-009 SHALL have port rsp_out, output, 32 bits: the result, valid only while rsp_valid=1.
REQ-010 SHALL have port flush, input, 1 bit: abandons any in-flight operation.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 SHALL drive req_ready=1 only in IDLE; the request is accepted on any rising edge where req_valid and req_ready are both 1.
REQ-013 SHALL latch op, in1 and in2 at acceptance; later changes to req_* inputs SHALL NOT affect the in-flight result.
REQ-014 On acceptance with a normal operand pair, SHALL go IDLE->CALC and run exactly 32 iterations: radix-2 shift-add for multiply, restoring shift-subtract for divide.
REQ-015 SHALL go CALC->DONE after the 32nd iteration, so rsp_valid rises 33 cycles after the accepting edge.
REQ-016 Special cases SHALL skip CALC (IDLE->DONE, rsp_valid one cycle after acceptance):
- divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> in1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- REM 0x80000000 / 0xFFFFFFFF -> 0.
REQ-017 Signed operations SHALL iterate on operand magnitudes and apply sign correction on DONE entry:
- quotient sign = sign(in1) XOR sign(in2).
- remainder sign = sign(in1).
REQ-018 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] using signed x signed, signed x unsigned, and unsigned x unsigned respectively.
REQ-019 In DONE, rsp_valid and rsp_out SHALL be held stable until rsp_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-020 SHALL NOT accept a new request in the cycle a response completes (no back-to-back overlap); req_ready rises on the following cycle.
REQ-021 flush=1 in CALC or DONE SHALL return the FSM to IDLE on the next edge with no response.
REQ-022 flush=1 in IDLE SHALL block acceptance that cycle.
REQ-023 flush SHALL take priority over rsp_ready and req_valid when asserted simultaneously.
REQ-024 The iteration counter SHALL be 6 bits, SHALL clear on acceptance, and SHALL NOT wrap within an operation.

Reset
REQ-025 rst=1 SHALL immediately force the FSM to IDLE, clear the counter and clear the operand/accumulator registers, independent of clk.
REQ-026 Output values under reset SHALL be: req_ready=1, rsp_valid=0, rsp_out=0.
REQ-027 Reset asserted mid-operation SHALL discard that operation; no response SHALL appear after release.

Structure
REQ-028 The mdu_op enum, the FSM state enum and the ITER=32 constant SHALL reside in shared package mduPkg, alongside aluPkg.
REQ-029 The sign-magnitude conversion and final sign correction SHALL be one sub-module, mdu_sign_fix; the remainder of the unit SHALL be flat.

Verification
REQ-030 MUL 10 x 2 -> rsp_out=20, rsp_valid exactly 33 cycles after acceptance.
REQ-031 MULH 0xFFFFFFFC (-4) x 4 -> 0xFFFFFFFF; MULHU with the same operands -> 0x00000003.
REQ-032 DIV 0xFFFFFFF0 (-16) / 2 -> 0xFFFFFFF8; REM 3 / 10 -> 3; DIVU 3 / 10 -> 0.
REQ-033 DIVU 3 / 0 -> 0xFFFFFFFF and REM 3 / 0 -> 3, each 1 cycle after acceptance; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-034 Hold rsp_ready=0 for 5 cycles in DONE -> rsp_out stable, req_ready=0 throughout; release -> IDLE, then the next request is accepted.
REQ-035 Assert flush at iteration 10, and separately rst at iteration 20 -> no rsp_valid; a following MUL 4 x 0xFFFFFFFC returns 0xFFFFFFF0.
